// File: rtl/weapon_bank.sv
// weapon_bank: N_CH independent weapon channels sharing one ammo capacity register.
// Each channel has a READY/COOL/RELOAD FSM, an ammo count and a cooldown counter.
module weapon_bank #(
    parameter int N_CH        = 4,
    parameter int W           = 9,
    parameter int COOLDOWN    = 3,
    parameter int RELOAD_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mode_selector,
    input  logic [N_CH-1:0]   fire,
    input  logic [N_CH-1:0]   reload,
    input  logic [W-1:0]      fire_rate,
    input  logic              cap_load,
    input  logic [W-1:0]      cap_in,
    output logic [N_CH*W-1:0] ammo,
    output logic [N_CH-1:0]   fired,
    output logic [N_CH-1:0]   error,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   empty
);
    typedef enum logic [1:0] {READY, COOL, RELOAD} state_t;
    logic [W-1:0] cap;
    logic         attack;
    assign attack = mode_selector == 4'b0010;
    always_ff @(posedge clk) begin
        if (!rst) cap <= '1;
        else if (cap_load) cap <= cap_in;
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t       st, st_n;
        logic [W-1:0] am, am_n, a, sat;
        logic [W:0]   sum;
        logic [3:0]   cnt, cnt_n;
        logic         fd, fd_n, er, er_n;
        // a is the ammo seen through the current cap, so a freshly lowered cap clamps on the next edge
        always_comb begin
            a     = am > cap ? cap : am;
            sum   = {1'b0, a} + (W+1)'(RELOAD_STEP);
            sat   = sum > {1'b0, cap} ? cap : sum[W-1:0];
            st_n  = st;
            am_n  = a;
            cnt_n = cnt;
            fd_n  = 1'b0;
            er_n  = 1'b0;
            case (st)
                READY: begin
                    if (reload[i]) begin
                        st_n = RELOAD;
                        am_n = sat;
                    end else if (fire[i]) begin
                        if (attack && fire_rate != '0 && a >= fire_rate) begin
                            am_n = a - fire_rate;
                            fd_n = 1'b1;
                            if (COOLDOWN != 0) begin
                                st_n  = COOL;
                                cnt_n = 4'(COOLDOWN - 1);
                            end
                        end else begin
                            er_n = 1'b1;
                        end
                    end
                end
                COOL: begin
                    if (reload[i]) begin
                        st_n = RELOAD;
                        am_n = sat;
                    end else if (cnt == 4'd0) begin
                        st_n = READY;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                default: begin
                    if (reload[i]) begin
                        am_n = sat;
                        st_n = sat == cap ? READY : RELOAD;
                    end else begin
                        st_n = READY;
                    end
                end
            endcase
        end
        always_ff @(posedge clk) begin
            if (!rst) begin
                st  <= READY;
                am  <= '0;
                cnt <= '0;
                fd  <= 1'b0;
                er  <= 1'b0;
            end else begin
                st  <= st_n;
                am  <= am_n;
                cnt <= cnt_n;
                fd  <= fd_n;
                er  <= er_n;
            end
        end
        assign ammo[i*W +: W] = am;
        assign fired[i]       = fd;
        assign error[i]       = er;
        assign busy[i]        = st != READY;
        assign empty[i]       = am == '0;
    end
endmodule

// File: tb/tb_weapon_bank.sv
// tb_weapon_bank: directed and random stimulus against a behavioural channel model,
// expected outputs queued per cycle and compared by an independent monitor.
module tb_weapon_bank;
    localparam int N = 4, W = 9, CD = 3, RS = 8;
    logic           clk = 1'b0, rst = 1'b0, cap_load = 1'b0;
    logic [3:0]     mode_selector = '0;
    logic [N-1:0]   fire = '0, reload = '0;
    logic [W-1:0]   fire_rate = '0, cap_in = '0;
    logic [N*W-1:0] ammo;
    logic [N-1:0]   fired, error, busy, empty;

    typedef struct packed {
        logic [N*W-1:0] ammo;
        logic [N-1:0]   fired, error, busy, empty;
    } exp_t;
    exp_t q[$];
    exp_t me;
    int   m_am[N], m_cool[N];
    bit   m_rel[N];
    int   m_cap = 511;
    int   errors = 0, checks = 0;

    weapon_bank #(.N_CH(N), .W(W), .COOLDOWN(CD), .RELOAD_STEP(RS)) dut (
        .clk(clk), .rst(rst), .mode_selector(mode_selector), .fire(fire), .reload(reload),
        .fire_rate(fire_rate), .cap_load(cap_load), .cap_in(cap_in), .ammo(ammo),
        .fired(fired), .error(error), .busy(busy), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic int mn(input int x, input int y);
        return x < y ? x : y;
    endfunction

    task automatic chk(input string n, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue what the DUT must show after the edge
    task automatic step(input logic r, input logic [3:0] md, input logic [N-1:0] f,
                        input logic [N-1:0] rl, input int fr, input logic cl, input int ci);
        exp_t e;
        e = '0;
        rst = r; mode_selector = md; fire = f; reload = rl;
        fire_rate = W'(fr); cap_load = cl; cap_in = W'(ci);
        for (int c = 0; c < N; c++) begin
            int a;
            if (!r) begin
                m_am[c] = 0; m_cool[c] = 0; m_rel[c] = 0;
            end else begin
                a = mn(m_am[c], m_cap);
                if (m_rel[c]) begin
                    if (rl[c]) begin
                        a = mn(a + RS, m_cap);
                        m_rel[c] = a != m_cap;
                    end else m_rel[c] = 0;
                end else if (m_cool[c] > 0) begin
                    if (rl[c]) begin
                        a = mn(a + RS, m_cap);
                        m_rel[c] = 1;
                        m_cool[c] = 0;
                    end else m_cool[c]--;
                end else if (rl[c]) begin
                    a = mn(a + RS, m_cap);
                    m_rel[c] = 1;
                end else if (f[c]) begin
                    if (md == 4'b0010 && fr != 0 && a >= fr) begin
                        a = a - fr;
                        e.fired[c] = 1'b1;
                        m_cool[c] = CD;
                    end else e.error[c] = 1'b1;
                end
                m_am[c] = a;
            end
            e.ammo[c*W +: W] = W'(m_am[c]);
            e.busy[c]  = m_cool[c] > 0 || m_rel[c];
            e.empty[c] = m_am[c] == 0;
        end
        if (!r) m_cap = 511;
        else if (cl) m_cap = ci;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("ammo", ammo, me.ammo);
            chk("fired", N*W'(fired), N*W'(me.fired));
            chk("error", N*W'(error), N*W'(me.error));
            chk("busy", N*W'(busy), N*W'(me.busy));
            chk("empty", N*W'(empty), N*W'(me.empty));
            chk("fired_and_error", N*W'(fired & error), '0);
        end
    end

    initial begin
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step(1, 2, 0, 4'b0001, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        repeat (8) step(1, 2, 4'b0001, 0, 10, 0, 0);
        step(1, 2, 4'b0001, 0, 20, 0, 0);
        step(1, 2, 0, 0, 20, 0, 0);
        step(1, 1, 4'b0001, 0, 10, 0, 0);
        repeat (12) step(1, 2, 0, 4'b0010, 10, 0, 0);
        step(1, 2, 0, 0, 10, 0, 0);
        step(1, 2, 0, 0, 10, 1, 100);
        repeat (2) step(1, 2, 0, 4'b0010, 10, 0, 0);
        step(1, 2, 0, 0, 10, 1, 50);
        step(1, 2, 0, 0, 10, 0, 0);
        repeat (2) step(1, 2, 0, 4'b1000, 10, 0, 0);
        step(1, 2, 0, 0, 10, 0, 0);
        step(1, 2, 4'b1100, 4'b0100, 5, 0, 0);
        repeat (2) step(1, 2, 0, 0, 5, 0, 0);
        step(1, 2, 0, 4'b0001, 5, 0, 0);
        step(0, 2, 0, 4'b0001, 5, 0, 0);
        step(1, 2, 0, 0, 5, 0, 0);
        step(1, 2, 0, 0, 5, 1, 0);
        step(1, 2, 4'b1111, 0, 5, 0, 0);
        step(1, 2, 4'b1111, 0, 0, 1, 511);
        repeat (600) begin
            logic [N-1:0] rl;
            for (int c = 0; c < N; c++) rl[c] = $urandom_range(3) == 0;
            step($urandom_range(99) != 0,
                 $urandom_range(9) < 7 ? 4'b0010 : 4'($urandom_range(15)),
                 N'($urandom_range(15)), rl, $urandom_range(30),
                 $urandom_range(39) == 0, $urandom_range(511));
        end
        step(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
